// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared types and helpers for the load/store sequencer: access size,
// lane masks, FSM state encoding and watchdog width.
package lsu_mem_ctrl_pkg;

  typedef enum logic [1:0] {
    DT_WORD = 2'b00,
    DT_BYTE = 2'b01,
    DT_HALF = 2'b10
  } data_type_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_BEAT0 = 2'b01,
    ST_BEAT1 = 2'b10,
    ST_DONE  = 2'b11
  } lsu_state_e;

  localparam int WDOG_W = 8;

  // Encoding 2'b11 behaves as a byte access.
  function automatic logic [2:0] lsu_size(input logic [1:0] dt);
    case (dt)
      DT_WORD: return 3'd4;
      DT_HALF: return 3'd2;
      default: return 3'd1;
    endcase
  endfunction

  function automatic logic [3:0] lsu_mask(input logic [1:0] dt);
    case (dt)
      DT_WORD: return 4'b1111;
      DT_HALF: return 4'b0011;
      default: return 4'b0001;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Word-wide data-memory bus with a req/ack handshake; the LSU is the master.
interface lsu_mem_ctrl_if;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ack, mem_rdata
  );

endinterface

// File: rtl/lsu_mem_ctrl_align.sv
// Byte-lane alignment: builds the two-beat byte-enable field and store lanes,
// and extracts/zero-extends load data from the merged two-word window.
module lsu_mem_ctrl_align
  import lsu_mem_ctrl_pkg::*;
(
  input  logic [1:0]  dtype_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [63:0] rword_i,
  output logic [7:0]  be_o,
  output logic [63:0] wlanes_o,
  output logic [31:0] rdata_o
);

  logic [31:0] rsh;

  always_comb begin
    be_o     = 8'({4'b0000, lsu_mask(dtype_i)} << off_i);
    wlanes_o = {32'b0, wdata_i} << {off_i, 3'b000};
    rsh      = 32'(rword_i >> {off_i, 3'b000});
    case (dtype_i)
      DT_WORD: rdata_o = rsh;
      DT_HALF: rdata_o = {16'b0, rsh[15:0]};
      default: rdata_o = {24'b0, rsh[7:0]};
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencer: captures a memory-stage access, runs one or two bus
// beats (two when the access crosses a word), and stalls until it completes.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting; captures a new access when read/write is asserted
//   ST_BEAT0 | first bus beat at the word holding the start address
//   ST_BEAT1 | second beat at the next word (word-crossing accesses only)
//   ST_DONE  | completion cycle: stall released, rdata_valid or bus_err
module lsu_mem_ctrl
  import lsu_mem_ctrl_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           mem_read_i,
  input  logic           mem_write_i,
  input  logic [1:0]     data_type_i,
  input  logic [31:0]    addr_i,
  input  logic [31:0]    wdata_i,
  output logic           stall_o,
  output logic [31:0]    rdata_o,
  output logic           rdata_valid_o,
  output logic           bus_err_o,
  lsu_mem_ctrl_if.master bus
);

  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(MAX_WAIT - 1);

  lsu_state_e        state_q, state_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        dtype_q, dtype_d;
  logic              we_q, we_d;
  logic              split_q, split_d;
  logic [31:0]       w0_q, w0_d;
  logic [31:0]       w1_q, w1_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              abort_q, abort_d;
  logic [31:0]       rdata_q, rdata_d;

  logic [7:0]  be8;
  logic [63:0] wlanes;
  logic [31:0] ld_data;
  logic [31:0] base_addr;
  logic        wdog_hit;
  logic        ld_ok;

  lsu_mem_ctrl_align u_align (
    .dtype_i  (dtype_q),
    .off_i    (addr_q[1:0]),
    .wdata_i  (wdata_q),
    .rword_i  ({w1_q, w0_q}),
    .be_o     (be8),
    .wlanes_o (wlanes),
    .rdata_o  (ld_data)
  );

  assign base_addr = {addr_q[31:2], 2'b00};
  assign wdog_hit  = (wdog_q == WDOG_LAST);
  assign ld_ok     = (state_q == ST_DONE) && !we_q && !abort_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    dtype_d = dtype_q;
    we_d    = we_q;
    split_d = split_q;
    w0_d    = w0_q;
    w1_d    = w1_q;
    wdog_d  = '0;
    abort_d = 1'b0;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (mem_read_i || mem_write_i) begin
          addr_d  = addr_i;
          wdata_d = wdata_i;
          dtype_d = data_type_i;
          we_d    = mem_write_i;
          split_d = ({1'b0, addr_i[1:0]} + lsu_size(data_type_i)) > 3'd4;
          state_d = ST_BEAT0;
        end
      end
      ST_BEAT0: begin
        // An ack in the limit cycle takes priority over the abort.
        if (bus.mem_ack) begin
          w0_d    = bus.mem_rdata;
          state_d = split_q ? ST_BEAT1 : ST_DONE;
        end else if (wdog_hit) begin
          abort_d = 1'b1;
          state_d = ST_DONE;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      ST_BEAT1: begin
        if (bus.mem_ack) begin
          w1_d    = bus.mem_rdata;
          state_d = ST_DONE;
        end else if (wdog_hit) begin
          abort_d = 1'b1;
          state_d = ST_DONE;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (ld_ok) rdata_d = ld_data;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      dtype_q <= '0;
      we_q    <= 1'b0;
      split_q <= 1'b0;
      w0_q    <= '0;
      w1_q    <= '0;
      wdog_q  <= '0;
      abort_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      dtype_q <= dtype_d;
      we_q    <= we_d;
      split_q <= split_d;
      w0_q    <= w0_d;
      w1_q    <= w1_d;
      wdog_q  <= wdog_d;
      abort_q <= abort_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_be    = '0;
    bus.mem_wdata = '0;
    if (state_q == ST_BEAT0) begin
      bus.mem_req   = 1'b1;
      bus.mem_we    = we_q;
      bus.mem_addr  = base_addr;
      bus.mem_be    = be8[3:0];
      bus.mem_wdata = we_q ? wlanes[31:0] : '0;
    end else if (state_q == ST_BEAT1) begin
      bus.mem_req   = 1'b1;
      bus.mem_we    = we_q;
      bus.mem_addr  = base_addr + 32'd4;
      bus.mem_be    = be8[7:4];
      bus.mem_wdata = we_q ? wlanes[63:32] : '0;
    end
  end

  assign stall_o       = (mem_read_i || mem_write_i) && (state_q != ST_DONE);
  assign rdata_valid_o = ld_ok;
  assign bus_err_o     = (state_q == ST_DONE) && abort_q;
  assign rdata_o       = ld_ok ? ld_data : rdata_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: a negedge bus responder with programmable
// ack delay, one task per scenario, hand-computed expectations.
module tb_lsu_mem_ctrl;

  logic        clk;
  logic        rst_n;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  data_type;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        bus_err;

  lsu_mem_ctrl_if bus_if ();

  lsu_mem_ctrl #(.MAX_WAIT(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem_read_i    (mem_read),
    .mem_write_i   (mem_write),
    .data_type_i   (data_type),
    .addr_i        (addr),
    .wdata_i       (wdata),
    .stall_o       (stall),
    .rdata_o       (rdata),
    .rdata_valid_o (rdata_valid),
    .bus_err_o     (bus_err),
    .bus           (bus_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mem [0:15];
  int          ack_at;
  int          ack_beats;
  int          req_cyc;
  int          nbeat;
  logic [31:0] b_addr  [0:3];
  logic [3:0]  b_be    [0:3];
  logic        b_we    [0:3];
  logic [31:0] b_wdata [0:3];

  int          stall_cyc;
  int          rv_cnt;
  int          err_cnt;
  int          req_total;
  logic [31:0] rdata_seen;
  logic [31:0] done_rdata;

  // Bus responder: acks on the ack_at-th request cycle of each beat.
  always @(negedge clk) begin
    if (bus_if.mem_req) begin
      req_cyc = req_cyc + 1;
      if (ack_at != 0 && req_cyc == ack_at && nbeat < ack_beats) begin
        bus_if.mem_ack   = 1'b1;
        bus_if.mem_rdata = mem[bus_if.mem_addr[5:2]];
        if (nbeat < 4) begin
          b_addr[nbeat]  = bus_if.mem_addr;
          b_be[nbeat]    = bus_if.mem_be;
          b_we[nbeat]    = bus_if.mem_we;
          b_wdata[nbeat] = bus_if.mem_wdata;
        end
        nbeat   = nbeat + 1;
        req_cyc = 0;
      end else begin
        bus_if.mem_ack = 1'b0;
      end
    end else begin
      bus_if.mem_ack = 1'b0;
      req_cyc        = 0;
    end
  end

  task automatic access(input logic rd, input logic wr, input logic [1:0] dt,
                        input logic [31:0] a, input logic [31:0] wd, input int ack_n);
    bit done;
    done      = 1'b0;
    nbeat     = 0;
    stall_cyc = 0;
    rv_cnt    = 0;
    err_cnt   = 0;
    req_total = 0;
    ack_at    = ack_n;
    @(posedge clk);
    #1;
    mem_read  = rd;
    mem_write = wr;
    data_type = dt;
    addr      = a;
    wdata     = wd;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (bus_if.mem_req) req_total++;
      if (stall) stall_cyc++;
      if (rdata_valid) begin rv_cnt++; rdata_seen = rdata; end
      if (bus_err) err_cnt++;
      if (!stall) begin done = 1'b1; done_rdata = rdata; end
    end
    n_cmp++;
    if (!done) begin n_bad++; $display("FAIL access_timeout addr=%h got no completion want completion", a); end
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (bus_if.mem_req !== 1'b0) begin n_bad++; $display("FAIL rst_req got %b want 0", bus_if.mem_req); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL rst_stall got %b want 0", stall); end
    n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL rst_rdata got %h want 0", rdata); end
    n_cmp++; if ({rdata_valid, bus_err, bus_if.mem_we} !== 3'b000) begin n_bad++; $display("FAIL rst_pulses got %b want 000", {rdata_valid, bus_err, bus_if.mem_we}); end
    n_cmp++; if ({bus_if.mem_addr, bus_if.mem_be} !== 36'h0) begin n_bad++; $display("FAIL rst_bus got %h/%b want 0/0", bus_if.mem_addr, bus_if.mem_be); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_lw_aligned();
    mem[0] = 32'hDEADBEEF;
    access(1'b1, 1'b0, 2'b00, 32'h100, 32'h0, 3);
    idle();
    n_cmp++; if (stall_cyc !== 4) begin n_bad++; $display("FAIL lw_stall got %0d want 4", stall_cyc); end
    n_cmp++; if (nbeat !== 1 || b_be[0] !== 4'b1111 || b_addr[0] !== 32'h100) begin n_bad++; $display("FAIL lw_beat got n=%0d be=%b a=%h want 1/1111/100", nbeat, b_be[0], b_addr[0]); end
    n_cmp++; if (rv_cnt !== 1 || rdata_seen !== 32'hDEADBEEF) begin n_bad++; $display("FAIL lw_rdata got %0d/%h want 1/deadbeef", rv_cnt, rdata_seen); end
    n_cmp++; if (req_total !== 3 || b_we[0] !== 1'b0) begin n_bad++; $display("FAIL lw_req got %0d/%b want 3/0", req_total, b_we[0]); end
  endtask

  task automatic test_sb();
    access(1'b0, 1'b1, 2'b01, 32'h103, 32'h000000AB, 1);
    idle();
    n_cmp++; if (nbeat !== 1 || b_addr[0] !== 32'h100 || b_be[0] !== 4'b1000) begin n_bad++; $display("FAIL sb_beat got n=%0d a=%h be=%b want 1/100/1000", nbeat, b_addr[0], b_be[0]); end
    n_cmp++; if (b_wdata[0] !== 32'hAB000000 || b_we[0] !== 1'b1) begin n_bad++; $display("FAIL sb_wdata got %h/%b want ab000000/1", b_wdata[0], b_we[0]); end
    n_cmp++; if (rv_cnt !== 0 || stall_cyc !== 2) begin n_bad++; $display("FAIL sb_done got rv=%0d stall=%0d want 0/2", rv_cnt, stall_cyc); end
  endtask

  task automatic test_misaligned_lw();
    mem[0] = 32'h44332211;
    mem[1] = 32'h88776655;
    access(1'b1, 1'b0, 2'b00, 32'h102, 32'h0, 1);
    idle();
    n_cmp++; if (nbeat !== 2 || b_be[0] !== 4'b1100 || b_be[1] !== 4'b0011) begin n_bad++; $display("FAIL mlw_be got n=%0d %b %b want 2 1100 0011", nbeat, b_be[0], b_be[1]); end
    n_cmp++; if (b_addr[0] !== 32'h100 || b_addr[1] !== 32'h104) begin n_bad++; $display("FAIL mlw_addr got %h %h want 100 104", b_addr[0], b_addr[1]); end
    n_cmp++; if (rv_cnt !== 1 || rdata_seen !== 32'h66554433 || stall_cyc !== 3) begin n_bad++; $display("FAIL mlw_rdata got %0d/%h/%0d want 1/66554433/3", rv_cnt, rdata_seen, stall_cyc); end
  endtask

  task automatic test_half_byte();
    mem[1] = 32'h88776655;
    mem[2] = 32'hCCBBAA99;
    access(1'b1, 1'b0, 2'b10, 32'h107, 32'h0, 1);
    idle();
    n_cmp++; if (nbeat !== 2 || b_be[0] !== 4'b1000 || b_be[1] !== 4'b0001) begin n_bad++; $display("FAIL lhu_be got n=%0d %b %b want 2 1000 0001", nbeat, b_be[0], b_be[1]); end
    n_cmp++; if (b_addr[0] !== 32'h104 || b_addr[1] !== 32'h108) begin n_bad++; $display("FAIL lhu_addr got %h %h want 104 108", b_addr[0], b_addr[1]); end
    n_cmp++; if (rdata_seen !== 32'h00009988 || rv_cnt !== 1) begin n_bad++; $display("FAIL lhu_rdata got %h/%0d want 00009988/1", rdata_seen, rv_cnt); end
    access(1'b1, 1'b0, 2'b01, 32'h106, 32'h0, 1);
    idle();
    n_cmp++; if (rdata_seen !== 32'h00000077 || b_be[0] !== 4'b0100 || nbeat !== 1) begin n_bad++; $display("FAIL lbu_rdata got %h/%b/%0d want 00000077/0100/1", rdata_seen, b_be[0], nbeat); end
  endtask

  task automatic test_sh_type11();
    access(1'b0, 1'b1, 2'b10, 32'h101, 32'h00001234, 2);
    idle();
    n_cmp++; if (b_be[0] !== 4'b0110 || b_wdata[0] !== 32'h00123400 || nbeat !== 1) begin n_bad++; $display("FAIL sh_lane got %b/%h/%0d want 0110/00123400/1", b_be[0], b_wdata[0], nbeat); end
    mem[0] = 32'h44332211;
    access(1'b1, 1'b0, 2'b11, 32'h101, 32'h0, 1);
    idle();
    n_cmp++; if (rdata_seen !== 32'h00000022 || b_be[0] !== 4'b0010) begin n_bad++; $display("FAIL dt11_byte got %h/%b want 00000022/0010", rdata_seen, b_be[0]); end
  endtask

  task automatic test_wrap();
    mem[15] = 32'hA1B2C3D4;
    mem[0]  = 32'h5566E7F8;
    access(1'b1, 1'b0, 2'b10, 32'hFFFFFFFF, 32'h0, 1);
    idle();
    n_cmp++; if (b_addr[0] !== 32'hFFFFFFFC || b_addr[1] !== 32'h0) begin n_bad++; $display("FAIL wrap_addr got %h %h want fffffffc 0", b_addr[0], b_addr[1]); end
    n_cmp++; if (rdata_seen !== 32'h0000F8A1) begin n_bad++; $display("FAIL wrap_rdata got %h want 0000f8a1", rdata_seen); end
  endtask

  task automatic test_watchdog();
    mem[0] = 32'h13572468;
    access(1'b1, 1'b0, 2'b00, 32'h100, 32'h0, 1);
    idle();
    access(1'b1, 1'b0, 2'b00, 32'h100, 32'h0, 0);
    idle();
    n_cmp++; if (req_total !== 4 || stall_cyc !== 5) begin n_bad++; $display("FAIL wd_req got req=%0d stall=%0d want 4/5", req_total, stall_cyc); end
    n_cmp++; if (err_cnt !== 1 || rv_cnt !== 0) begin n_bad++; $display("FAIL wd_err got err=%0d rv=%0d want 1/0", err_cnt, rv_cnt); end
    n_cmp++; if (done_rdata !== 32'h13572468) begin n_bad++; $display("FAIL wd_rdata_hold got %h want 13572468", done_rdata); end
    @(negedge clk);
    n_cmp++; if (bus_err !== 1'b0 || bus_if.mem_req !== 1'b0) begin n_bad++; $display("FAIL wd_idle got err=%b req=%b want 0/0", bus_err, bus_if.mem_req); end
    mem[0] = 32'h2468ACE0;
    access(1'b1, 1'b0, 2'b00, 32'h100, 32'h0, 4);
    idle();
    n_cmp++; if (err_cnt !== 0 || rv_cnt !== 1 || rdata_seen !== 32'h2468ACE0 || req_total !== 4) begin n_bad++; $display("FAIL wd_ack_at_limit got err=%0d rv=%0d %h req=%0d want 0/1/2468ace0/4", err_cnt, rv_cnt, rdata_seen, req_total); end
  endtask

  task automatic test_reset_mid_split();
    int pulses;
    nbeat     = 0;
    ack_at    = 1;
    ack_beats = 1;
    @(posedge clk);
    #1;
    mem_write = 1'b1;
    data_type = 2'b00;
    addr      = 32'h102;
    wdata     = 32'h11223344;
    repeat (3) @(negedge clk);
    n_cmp++; if (b_be[0] !== 4'b1100 || b_wdata[0] !== 32'h33440000) begin n_bad++; $display("FAIL sw_beat0 got %b/%h want 1100/33440000", b_be[0], b_wdata[0]); end
    n_cmp++; if (bus_if.mem_req !== 1'b1 || bus_if.mem_addr !== 32'h104 || bus_if.mem_be !== 4'b0011 || bus_if.mem_wdata !== 32'h00001122) begin n_bad++; $display("FAIL sw_beat1 got %b/%h/%b/%h want 1/104/0011/00001122", bus_if.mem_req, bus_if.mem_addr, bus_if.mem_be, bus_if.mem_wdata); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus_if.mem_req !== 1'b0 || rdata_valid !== 1'b0 || bus_err !== 1'b0) begin n_bad++; $display("FAIL mid_rst got req=%b rv=%b err=%b want 0/0/0", bus_if.mem_req, rdata_valid, bus_err); end
    mem_write = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ack_beats = 99;
    pulses = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus_if.mem_req || rdata_valid || bus_err || stall) pulses++;
    end
    n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL post_rst_quiet got %0d active cycles want 0", pulses); end
  endtask

  task automatic test_back_to_back();
    mem[0] = 32'h0BADF00D;
    access(1'b1, 1'b1, 2'b00, 32'h108, 32'hCAFEF00D, 1);
    n_cmp++; if (b_we[0] !== 1'b1 || b_wdata[0] !== 32'hCAFEF00D || rv_cnt !== 0) begin n_bad++; $display("FAIL rw_as_write got we=%b %h rv=%0d want 1/cafef00d/0", b_we[0], b_wdata[0], rv_cnt); end
    access(1'b1, 1'b0, 2'b00, 32'h100, 32'h0, 1);
    idle();
    n_cmp++; if (stall_cyc !== 2 || rv_cnt !== 1 || rdata_seen !== 32'h0BADF00D) begin n_bad++; $display("FAIL b2b_lw got stall=%0d rv=%0d %h want 2/1/0badf00d", stall_cyc, rv_cnt, rdata_seen); end
  endtask

  initial begin
    rst_n            = 1'b0;
    mem_read         = 1'b0;
    mem_write        = 1'b0;
    data_type        = 2'b00;
    addr             = 32'h0;
    wdata            = 32'h0;
    bus_if.mem_ack   = 1'b0;
    bus_if.mem_rdata = 32'h0;
    ack_at           = 1;
    ack_beats        = 99;
    req_cyc          = 0;
    nbeat            = 0;
    rdata_seen       = 32'h0;
    done_rdata       = 32'h0;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    for (int i = 0; i < 4; i++) begin
      b_addr[i] = 32'h0; b_be[i] = 4'h0; b_we[i] = 1'b0; b_wdata[i] = 32'h0;
    end

    test_reset();
    test_lw_aligned();
    test_sb();
    test_misaligned_lw();
    test_half_byte();
    test_sh_type11();
    test_wrap();
    test_watchdog();
    test_reset_mid_split();
    test_back_to_back();

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
